// File: rtl/add_mul_acc.sv
// Free-running convolution multiply-accumulate element: one weight*pixel product per clock,
// publishes a saturated window sum and a done pulse every KERNEL_TAPS cycles.
module add_mul_acc #(
    parameter int DATA_W      = 8,
    parameter int OUT_W       = 17,
    parameter int KERNEL_TAPS = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] kernel_weights,
    input  logic [DATA_W-1:0] in_pix,
    output logic [OUT_W-1:0]  out_pix,
    output logic              ind,
    output logic              done
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = PROD_W + $clog2(KERNEL_TAPS);
    localparam int SUM_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W + 1;
    localparam int CNT_W  = (KERNEL_TAPS > 1) ? $clog2(KERNEL_TAPS) : 1;
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(KERNEL_TAPS - 1);
    localparam logic [SUM_W-1:0] SAT_LIM  = SUM_W'((64'd1 << OUT_W) - 64'd1);

    // Taps remaining in the window, counted down: LAST_TAP means tap 0 is next, 0 means final tap.
    logic [CNT_W-1:0]  taps_left;
    logic [ACC_W-1:0]  acc;
    logic [PROD_W-1:0] product;
    logic [SUM_W-1:0]  sum;
    logic              first_tap;
    logic              last_tap;

    assign first_tap = (taps_left == LAST_TAP);
    assign last_tap  = (taps_left == '0);
    assign product   = PROD_W'(kernel_weights) * PROD_W'(in_pix);
    // Tap 0 ignores the old accumulator, so windows run back-to-back without a clear cycle.
    assign sum       = SUM_W'(product) + (first_tap ? '0 : SUM_W'(acc));
    assign ind       = first_tap & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            taps_left <= LAST_TAP;
            acc       <= '0;
            out_pix   <= '0;
            done      <= 1'b0;
        end else begin
            done <= last_tap;
            acc  <= sum[ACC_W-1:0];
            if (last_tap) begin
                taps_left <= LAST_TAP;
                out_pix   <= (sum > SAT_LIM) ? '1 : sum[OUT_W-1:0];
            end else begin
                taps_left <= taps_left - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_add_mul_acc.sv
// Scoreboard bench for add_mul_acc: a 9-tap and a 1-tap instance share stimulus; a window-sum
// model pushes expected results, a negedge monitor pops and compares whenever done is seen.
module tb_add_mul_acc;
    localparam int SAT = 131071;

    typedef struct {
        longint val;
        longint cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  w = '0;
    logic [7:0]  p = '0;
    logic [1:0]  done_v;
    logic [1:0]  ind_v;
    logic [16:0] out9;
    logic [16:0] out1;

    int     errors = 0;
    int     checks = 0;
    longint cyc = 0;
    bit     last_rst = 1'b1;
    bit     mon_on = 1'b0;

    exp_t   q9[$];
    exp_t   q1[$];
    int     taps_k[2] = '{9, 1};
    int     tap_idx[2];
    longint wsum[2];
    longint held[2];

    add_mul_acc #(.DATA_W(8), .OUT_W(17), .KERNEL_TAPS(9)) dut9 (
        .clk(clk), .rst(rst), .kernel_weights(w), .in_pix(p),
        .out_pix(out9), .ind(ind_v[0]), .done(done_v[0])
    );

    add_mul_acc #(.DATA_W(8), .OUT_W(17), .KERNEL_TAPS(1)) dut1 (
        .clk(clk), .rst(rst), .kernel_weights(w), .in_pix(p),
        .out_pix(out1), .ind(ind_v[1]), .done(done_v[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      = cyc + 1;
        last_rst = rst;
    end

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    // One clock of stimulus: drive at negedge, check ind, then advance the window model.
    task automatic step(input bit r, input int wv, input int pv);
        exp_t e;
        @(negedge clk);
        rst = r;
        w   = 8'(wv);
        p   = 8'(pv);
        #1;
        for (int i = 0; i < 2; i++) begin
            check(i == 0 ? "ind_k9" : "ind_k1", longint'(ind_v[i]),
                  longint'(!r && tap_idx[i] == 0));
            if (r) begin
                tap_idx[i] = 0;
                wsum[i]    = 0;
            end else begin
                wsum[i] = (tap_idx[i] == 0) ? longint'(wv * pv) : wsum[i] + longint'(wv * pv);
                tap_idx[i]++;
                if (tap_idx[i] == taps_k[i]) begin
                    e.val = (wsum[i] > SAT) ? SAT : wsum[i];
                    e.cyc = cyc + 1;
                    if (i == 0) q9.push_back(e);
                    else        q1.push_back(e);
                    tap_idx[i] = 0;
                end
            end
        end
        mon_on = 1'b1;
    endtask

    task automatic mon_unit(input int i, input logic d, input logic [16:0] o);
        exp_t   e;
        bit     have;
        string  tag;
        tag = (i == 0) ? "k9" : "k1";
        // Entries whose cycle has passed without a done pulse are missed windows.
        forever begin
            have = 1'b0;
            if (i == 0 && q9.size() > 0 && q9[0].cyc < cyc) begin e = q9.pop_front(); have = 1'b1; end
            if (i == 1 && q1.size() > 0 && q1[0].cyc < cyc) begin e = q1.pop_front(); have = 1'b1; end
            if (!have) break;
            check({"missed_done_", tag}, 0, e.cyc);
        end
        if (last_rst) begin
            check({"rst_done_", tag}, longint'(d), 0);
            check({"rst_out_", tag}, longint'(o), 0);
            held[i] = 0;
        end else if (d) begin
            have = 1'b0;
            if (i == 0 && q9.size() > 0) begin e = q9.pop_front(); have = 1'b1; end
            if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            if (!have) begin
                check({"spurious_done_", tag}, 1, 0);
            end else begin
                check({"done_cycle_", tag}, cyc, e.cyc);
                check({"out_pix_", tag}, longint'(o), e.val);
                held[i] = e.val;
            end
        end else begin
            check({"out_hold_", tag}, longint'(o), held[i]);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            mon_unit(0, done_v[0], out9);
            mon_unit(1, done_v[1], out1);
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            tap_idx[i] = 0;
            wsum[i]    = 0;
            held[i]    = 0;
        end
        for (int i = 0; i < 3; i++) step(1'b1, 0, 0);
        for (int i = 0; i < 27; i++) step(1'b0, 5, 3);
        for (int i = 1; i <= 9; i++) step(1'b0, i, 2);
        for (int i = 0; i < 9; i++) step(1'b0, 0, 2);
        for (int i = 0; i < 9; i++) step(1'b0, 255, 255);
        for (int i = 0; i < 4; i++) step(1'b0, 5, 3);
        step(1'b1, 5, 3);
        for (int i = 0; i < 9; i++) step(1'b0, 5, 3);
        for (int i = 0; i < 5; i++) step(1'b0, 7, 11);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 59) == 0)
                step(1'b1, $urandom_range(0, 255), $urandom_range(0, 255));
            else if ($urandom_range(0, 3) == 0)
                step(1'b0, $urandom_range(200, 255), $urandom_range(200, 255));
            else
                step(1'b0, $urandom_range(0, 255), $urandom_range(0, 255));
        end
        // Finish the open window so every pushed expectation gets consumed.
        while (tap_idx[0] != 0) step(1'b0, 1, 1);
        step(1'b0, 1, 1);
        step(1'b0, 1, 1);
        check("pending_k9", longint'(q9.size()), 0);
        check("pending_k1", longint'(q1.size()), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
